// File: rtl/lcd1602_i2c_sequencer.sv
// rtl/lcd1602_i2c_sequencer.sv - HD44780 (4-bit, PCF8574 backpack) write sequencer for a byte-write I2C master
//
// Purpose: waits out LCD power-up, optionally replays the HD44780 4-bit init
// sequence, then accepts instruction/character bytes and turns each into
// four PCF8574 writes (high nibble EN=1/EN=0, low nibble EN=1/EN=0),
// followed by the controller settle delay.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   req_valid/ready   request handshake; transfer when both high
//   req_rs, req_data  register select and byte for the LCD
//   backlight         BL bit, sampled as each I2C byte is built
//   i2c_start         one-cycle write strobe to the I2C master
//   i2c_addr          constant PCF8574 slave address
//   i2c_data          PCF8574 byte {D7..D4, BL, EN, RW=0, RS}
//   i2c_busy          master busy, rises the cycle after i2c_start
//   i2c_ack_err       NACK flag, valid in the cycle i2c_busy falls
//   init_done         high once the LCD is ready for requests
//   err               sticky NACK flag
//
// Build option: LCD_INIT_EN enables the built-in init ROM; without it the
// requester is responsible for sending the init commands.

module lcd1602_i2c_sequencer #(
  parameter logic [6:0] I2C_ADDR       = 7'h27,
  parameter int         POWERUP_CYCLES = 600000,
  parameter int         CMD_CYCLES     = 600,
  parameter int         LONG_CYCLES    = 60000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  input  logic       backlight,
  output logic       i2c_start,
  output logic [6:0] i2c_addr,
  output logic [7:0] i2c_data,
  input  logic       i2c_busy,
  input  logic       i2c_ack_err,
  output logic       init_done,
  output logic       err
);

  localparam int CW = $clog2(POWERUP_CYCLES + 1);

  localparam logic [2:0] S_POWERUP = 3'd0;
`ifdef LCD_INIT_EN
  localparam logic [2:0] S_INIT    = 3'd1;
`endif
  localparam logic [2:0] S_IDLE    = 3'd2;
  localparam logic [2:0] S_LOAD    = 3'd3;
  localparam logic [2:0] S_ISSUE   = 3'd4;
  localparam logic [2:0] S_GAP     = 3'd5;
  localparam logic [2:0] S_WAIT    = 3'd6;
  localparam logic [2:0] S_DELAY   = 3'd7;

  localparam logic [CW-1:0] PU_LAST   = CW'(POWERUP_CYCLES - 1);
  // The WAIT cycle in which busy falls already counts as the first settle
  // cycle, so DELAY itself runs for N-1 cycles (terminal count N-2).
  localparam logic [CW-1:0] CMD_LAST  = CW'(CMD_CYCLES - 2);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 2);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          item_rs;
  logic [7:0]    item_data;
  logic          item_nibble;  // nibble-only item: only data[7:4] is sent
  logic          item_long;    // item needs the long settle delay
  logic [1:0]    wr_idx;       // [1] selects low nibble, [0]=1 is the EN-low write

  logic          last_wr;
  logic [3:0]    cur_nib;
  logic [CW-1:0] delay_last;

`ifdef LCD_INIT_EN
  logic [2:0] init_idx;

  // Init ROM entry: {nibble_only, long_delay, data}
  function automatic logic [9:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    init_rom = {1'b1, 1'b1, 8'h30};
      3'd1:    init_rom = {1'b1, 1'b0, 8'h30};
      3'd2:    init_rom = {1'b1, 1'b0, 8'h30};
      3'd3:    init_rom = {1'b1, 1'b0, 8'h20};
      3'd4:    init_rom = {1'b0, 1'b0, 8'h28};
      3'd5:    init_rom = {1'b0, 1'b0, 8'h0C};
      3'd6:    init_rom = {1'b0, 1'b0, 8'h06};
      default: init_rom = {1'b0, 1'b1, 8'h01};
    endcase
  endfunction
`endif

  assign i2c_addr   = I2C_ADDR;
  assign req_ready  = (state == S_IDLE) && init_done;
  assign i2c_start  = (state == S_ISSUE) && !i2c_busy;
  assign last_wr    = item_nibble ? (wr_idx == 2'd1) : (wr_idx == 2'd3);
  assign cur_nib    = wr_idx[1] ? item_data[3:0] : item_data[7:4];
  assign delay_last = item_long ? LONG_LAST : CMD_LAST;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_POWERUP;
      cnt         <= '0;
      item_rs     <= 1'b0;
      item_data   <= 8'h00;
      item_nibble <= 1'b0;
      item_long   <= 1'b0;
      wr_idx      <= 2'd0;
      i2c_data    <= 8'h00;
      init_done   <= 1'b0;
      err         <= 1'b0;
`ifdef LCD_INIT_EN
      init_idx    <= 3'd0;
`endif
    end else begin
      case (state)
        S_POWERUP: begin
          if (cnt == PU_LAST) begin
            cnt <= '0;
`ifdef LCD_INIT_EN
            init_idx <= 3'd0;
            state    <= S_INIT;
`else
            init_done <= 1'b1;
            state     <= S_IDLE;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef LCD_INIT_EN
        S_INIT: begin
          {item_nibble, item_long, item_data} <= init_rom(init_idx);
          item_rs <= 1'b0;
          wr_idx  <= 2'd0;
          state   <= S_LOAD;
        end
`endif

        S_IDLE: begin
          if (req_valid && init_done) begin
            item_rs     <= req_rs;
            item_data   <= req_data;
            item_nibble <= 1'b0;
            // clear display / return home need the long settle time
            item_long   <= !req_rs && (req_data[7:2] == 6'd0) && (req_data[1:0] != 2'd0);
            wr_idx      <= 2'd0;
            state       <= S_LOAD;
          end
        end

        S_LOAD: begin
          i2c_data <= {cur_nib, backlight, ~wr_idx[0], 1'b0, item_rs};
          state    <= S_ISSUE;
        end

        S_ISSUE: begin
          if (!i2c_busy) state <= S_GAP;
        end

        // Master raises busy one cycle after start; skip that cycle so the
        // stale low busy is not mistaken for completion.
        S_GAP: state <= S_WAIT;

        S_WAIT: begin
          if (!i2c_busy) begin
            if (i2c_ack_err) err <= 1'b1;
            if (last_wr) begin
              cnt   <= '0;
              state <= S_DELAY;
            end else begin
              wr_idx <= wr_idx + 2'd1;
              state  <= S_LOAD;
            end
          end
        end

        S_DELAY: begin
          if (cnt == delay_last) begin
            cnt <= '0;
`ifdef LCD_INIT_EN
            if (!init_done) begin
              if (init_idx == 3'd7) begin
                init_done <= 1'b1;
                state     <= S_IDLE;
              end else begin
                init_idx <= init_idx + 3'd1;
                state    <= S_INIT;
              end
            end else begin
              state <= S_IDLE;
            end
`else
            state <= S_IDLE;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          cnt   <= '0;
          state <= S_POWERUP;
        end
      endcase
    end
  end

endmodule
